// File: rtl/onehot_seq_pkg.sv
// Shared bounds and modulus helpers for the one-hot sequencing counter.
package onehot_seq_pkg;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 64;

    // Out-of-range moduli fall back to the full length so the sequence never stalls.
    function automatic int unsigned eff_mod(input int unsigned modulus, input int unsigned n);
        if (modulus >= 2 && modulus <= n) begin
            return modulus;
        end
        return n;
    endfunction

    function automatic int unsigned half_ceil(input int unsigned m);
        return (m + 1) / 2;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decoder feeding the q register.
module onehot_decode
    import onehot_seq_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned CNT_W = $clog2(N)
) (
    input  logic [CNT_W-1:0] bin_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bin_i == CNT_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_seq_counter.sv
// Programmable-modulus one-hot sequencing counter with preload, carry and terminal count.
// Down-counting is built only when ONEHOT_SEQ_COUNTER_UPDOWN_EN is defined.
module onehot_seq_counter
    import onehot_seq_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned CNT_W = $clog2(N),
    parameter int unsigned MOD_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic [MOD_W-1:0] modulus,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic [N-1:0]     q,
    output logic             carry_out,
    output logic             tc
);

    // One extra bit keeps M_eff itself representable when N is a power of two.
    localparam int unsigned AW = CNT_W + 1;

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("onehot_seq_counter: N out of range");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     q_q, q_d;
    logic             carry_q, carry_d;
    logic             tc_q, tc_d;

    logic [AW-1:0]    m_eff;
    logic [AW-1:0]    half;
    logic [AW-1:0]    cnt_ext;
    logic             upd;

    assign m_eff   = AW'(eff_mod(32'(modulus), N));
    assign half    = AW'(half_ceil(32'(m_eff)));
    assign cnt_ext = {1'b0, count_q};

`ifndef ONEHOT_SEQ_COUNTER_UPDOWN_EN
    logic dir_unused;
    assign dir_unused = dir;
`endif

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        upd     = 1'b0;
        if (load) begin
            upd = 1'b1;
            if ({1'b0, load_val} < m_eff) begin
                count_d = load_val;
            end else begin
                count_d = '0;
            end
        end else if (enable) begin
            upd = 1'b1;
`ifdef ONEHOT_SEQ_COUNTER_UPDOWN_EN
            if (dir) begin
                if (cnt_ext == '0 || cnt_ext >= m_eff) begin
                    count_d = CNT_W'(m_eff - AW'(1));
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end else
`endif
            begin
                // Covers both the normal wrap and a count stranded above a shrunken modulus.
                if (cnt_ext >= m_eff - AW'(1)) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = CNT_W'(cnt_ext + AW'(1));
                end
            end
        end
        // Holding keeps carry as it was, so a modulus change while idle is not applied retroactively.
        carry_d = upd ? ({1'b0, count_d} < half) : carry_q;
    end

    onehot_decode #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_decode (
        .bin_i    (count_d),
        .onehot_o (q_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            q_q     <= N'(1);
            carry_q <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            tc_q    <= tc_d;
        end
    end

    assign count     = count_q;
    assign q         = q_q;
    assign carry_out = carry_q;
    assign tc        = tc_q;

endmodule

// File: tb/tb_onehot_seq_counter.sv
// Scoreboard bench for onehot_seq_counter (N=10): driver queues expectations, monitor checks each cycle.
module tb_onehot_seq_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] modulus = 4'd10;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic [9:0] q;
    logic       carry_out;
    logic       tc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cnt;
        logic [9:0] q;
        logic       carry;
        logic       tc;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];

    onehot_seq_counter #(.N(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dir       (dir),
        .modulus   (modulus),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .q         (q),
        .carry_out (carry_out),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic en, input logic dr, input int md,
                         input logic ld, input int lv, input int ec, input logic etc,
                         input int meff, input string nm);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        enable   = en;
        dir      = dr;
        modulus  = 4'(md);
        load     = ld;
        load_val = 4'(lv);
        e.cnt    = 4'(ec);
        e.q      = 10'(1) << ec;
        e.carry  = (ec < (meff + 1) / 2);
        e.tc     = etc;
        sb.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = nm_q.pop_front();
                checks += 4;
                if (count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s count got %0d want %0d", nm, count, e.cnt);
                end
                if (q !== e.q) begin
                    errors++;
                    $display("FAIL %s q got %b want %b", nm, q, e.q);
                end
                if (carry_out !== e.carry) begin
                    errors++;
                    $display("FAIL %s carry_out got %b want %b (count %0d)", nm, carry_out, e.carry, e.cnt);
                end
                if (tc !== e.tc) begin
                    errors++;
                    $display("FAIL %s tc got %b want %b (count %0d)", nm, tc, e.tc, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int c;
        drive(1, 0, 0, 10, 0, 0, 0, 0, 10, "reset");

        for (int k = 1; k <= 12; k++) begin
            c = k % 10;
            drive(0, 1, 0, 10, 0, 0, c, c == 0, 10, "up_mod10");
        end
        for (int k = 1; k <= 10; k++) begin
            c = (2 + k) % 6;
            drive(0, 1, 0, 6, 0, 0, c, c == 0, 6, "up_mod6");
        end
        for (int k = 1; k <= 10; k++) begin
            c = k % 10;
            drive(0, 1, 0, 0, 0, 0, c, c == 0, 10, "up_mod0");
        end
        for (int k = 1; k <= 10; k++) begin
            c = k % 10;
            drive(0, 1, 0, 15, 0, 0, c, c == 0, 10, "up_mod15");
        end

`ifdef ONEHOT_SEQ_COUNTER_UPDOWN_EN
        drive(0, 1, 1, 10, 0, 0, 9, 1, 10, "down_wrap");
        drive(0, 1, 1, 10, 0, 0, 8, 0, 10, "down");
        drive(0, 1, 1, 10, 0, 0, 7, 0, 10, "down");
        drive(0, 1, 0, 10, 0, 0, 8, 0, 10, "reverse_up");
        drive(0, 1, 0, 10, 0, 0, 9, 0, 10, "reverse_up");
        drive(0, 1, 0, 10, 0, 0, 0, 1, 10, "reverse_wrap");
`else
        drive(0, 1, 1, 10, 0, 0, 1, 0, 10, "dir_ignored");
        drive(0, 1, 1, 10, 0, 0, 2, 0, 10, "dir_ignored");
        drive(0, 1, 1, 10, 0, 0, 3, 0, 10, "dir_ignored");
        drive(0, 1, 0, 10, 0, 0, 4, 0, 10, "up_after_dir");
        drive(0, 1, 0, 10, 0, 0, 5, 0, 10, "up_after_dir");
        drive(0, 1, 0, 10, 0, 0, 6, 0, 10, "up_after_dir");
`endif

        drive(0, 0, 0, 10, 1, 7, 7, 0, 10, "load7");
        drive(0, 0, 0, 10, 1, 12, 0, 0, 10, "load12_oor");
        drive(0, 1, 0, 10, 1, 3, 3, 0, 10, "load_beats_en");
        drive(0, 0, 0, 10, 1, 9, 9, 0, 10, "load9");
        drive(0, 1, 0, 10, 0, 0, 0, 1, 10, "wrap_after_load");

        drive(0, 0, 0, 10, 1, 8, 8, 0, 10, "load8");
        drive(0, 1, 0, 5, 0, 0, 0, 1, 5, "shrink_mod5");
        drive(0, 1, 0, 5, 0, 0, 1, 0, 5, "mod5_step");
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 5, 0, 0, 1, 0, 5, "hold");
        end

        drive(0, 1, 0, 2, 0, 0, 0, 1, 2, "mod2");
        drive(0, 1, 0, 2, 0, 0, 1, 0, 2, "mod2");
        drive(0, 1, 0, 2, 0, 0, 0, 1, 2, "mod2");
        drive(0, 1, 0, 2, 0, 0, 1, 0, 2, "mod2");

        drive(0, 0, 0, 10, 1, 6, 6, 0, 10, "load6");
        drive(1, 1, 0, 10, 1, 3, 0, 0, 10, "reset_overrides");
        drive(0, 1, 0, 10, 0, 0, 1, 0, 10, "after_reset");

        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_seq_counter.md
# onehot_seq_counter

Parametrised one-hot sequencing counter: the generalised successor of the fixed ten-output decade counter. It has N one-hot outputs, a runtime-programmable modulus, optional up/down counting, synchronous preload, a half-cycle carry output and a terminal-count pulse. It sits in the sequencing and timing section, driving step strobes for multiplexed displays, scanners and phase generators.

## Interface
Parameters:
- N, default 10, number of one-hot outputs; legal range 2..64.
- CNT_W, default $clog2(N), binary count width. Derived; never overridden.
- MOD_W, default $clog2(N+1), width of the modulus input. Derived.

Ports:
- clk  in  1  rising-edge clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable, active-high. When low, the counter holds.
- dir  in  1  0 = count up, 1 = count down. Honoured only with the macro (see Configuration).
- modulus  in  MOD_W  sequence length M.
- load  in  1  synchronous preload strobe.
- load_val  in  CNT_W  preload value.
- count  out  CNT_W  registered binary state.
- q  out  N  registered one-hot decode of count.
- carry_out  out  1  registered; high during the first half of the sequence.
- tc  out  1  registered single-cycle pulse on a wrap.

## Operation
- Effective modulus: M_eff = modulus when 2 ≤ modulus ≤ N; otherwise M_eff = N. M_eff is evaluated combinationally every cycle.
- Priority at each rising edge: reset, then load, then enable, then hold.
- reset: count=0, q=1 (only bit 0 set), carry_out=1, tc=0.
- load: count = load_val when load_val < M_eff; otherwise count = 0. A load never asserts tc.
- enable, counting up:
  - count == M_eff-1 → 0, with tc=1.
  - count ≥ M_eff (possible after modulus shrinks) → 0, with tc=1.
  - otherwise count+1.
- enable, counting down:
  - count == 0 → M_eff-1, with tc=1.
  - count ≥ M_eff → M_eff-1, with tc=1.
  - otherwise count-1.
- q[i] = (count_next == i). Exactly one bit of q is high in every cycle after reset. Bits at or above M_eff never assert while the counter is in range.
- carry_out = (count_next < ceil(M_eff/2)). For M_eff=10 it is high for counts 0..4.
- tc is low in every cycle that does not immediately follow a wrap edge.
- Arithmetic is done at CNT_W+1 bits internally, so there is no overflow at N = 2^CNT_W.

## Timing
- All outputs are registered and update on the same edge; count, q and carry_out are always mutually consistent.
- Latency is 1 cycle from enable, load or reset sampled high to the new output values.
- A change on modulus takes effect at the next enabled edge. There is no retroactive correction while holding.
- Reset asserted mid-sequence overrides load and enable in the same cycle.
- With M_eff=2, tc pulses on every second enabled edge.
- A dir change takes effect on the next enabled edge, and the sequence reverses without skipping a state.

## Configuration
- Macro: ONEHOT_SEQ_COUNTER_UPDOWN_EN.
- Defined: dir is honoured as described under Operation.
- Undefined: dir is ignored and the counter always counts up. The port remains present so instantiations are identical in both builds. The down-count logic is not synthesised.

## Structure
- Package onehot_seq_pkg holds:
  - the N legal-range bounds (N_MIN=2, N_MAX=64);
  - a function eff_mod(modulus, N) returning M_eff;
  - a function half_ceil(m) used for the carry_out threshold.
- Sub-module onehot_decode, parameter N: a purely combinational binary-to-one-hot decoder. It is instantiated once on count_next, and its output feeds the q register.

## Test plan
- Reset, then enable=1, N=10, modulus=10, 12 cycles → q walks bit 0..9 then back to 0; tc=1 only in the cycle after 9→0; carry_out high for counts 0..4.
- modulus=6 → count sequence 0..5,0; q[9:6] never asserted; carry_out high for counts 0..2; modulus=0 and modulus=15 both behave as M_eff=10.
- With the macro defined, dir=1 from count 0 and M_eff=10 → count goes to 9 with tc=1, then 8, 7, …; without the macro the same stimulus counts up.
- load=1 with load_val=7 → count=7, q=8'h80 in the low byte, tc=0; load_val=12 → count=0; load together with enable → the load wins.
- At count=8, change modulus to 5 → the next enabled edge gives count 0 with tc=1; enable=0 for 5 cycles → all outputs hold.
- Reset pulsed at count=6 with enable=1 and load=1 → the next cycle shows count=0, q=1, carry_out=1, tc=0.
